// File: rtl/fp_norm_pkg.sv
// Shared constants and the stage-1 to stage-2 payload for the post-add normaliser.
package fp_norm_pkg;

  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLG_OF   = 3;
  localparam int FLG_UF   = 2;
  localparam int FLG_NX   = 1;
  localparam int FLG_ZERO = 0;

  // Normalised beat: fraction below the hidden bit, signed exponent with two guard bits.
  typedef struct packed {
    logic                        sign;
    logic [FP_MANT_W-1:0]        mant;
    logic signed [FP_EXP_W+1:0]  exp;
    logic [2:0]                  grs;
    logic [1:0]                  rm;
    logic                        zero;
  } norm_stage_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input counts as W.
module fp_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]               in_bits,
  output logic [$clog2(W+1)-1:0]     count
);

  localparam int CW = $clog2(W+1);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (in_bits[i]) found = 1'b1;
        else            count = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normalise / round pipeline between the mantissa adder and result packing.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W+4:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [1:0]        in_rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [3:0]        out_flags
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // Valid never waits on ready, and a stalled output holds its data until taken.

  localparam int SW   = MANT_W + 4;
  localparam int LZ_W = $clog2(SW + 1);

  localparam logic signed [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_INF  = {2'b00, {EXP_W{1'b1}}};

  norm_stage_t       s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              rdy_en_q, rdy_en_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sign_q, out_sign_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [3:0]        out_flags_q, out_flags_d;

  logic                    s2_advance;
  logic [LZ_W-1:0]         lz;
  logic [SW-1:0]           shifted;
  logic signed [EXP_W+1:0] exp_in, exp_n;

  logic                    inexact, round_up, ovf_to_inf;
  logic [MANT_W:0]         frac_sum;
  logic signed [EXP_W+1:0] exp_r;
  logic [MANT_W-1:0]       res_mant;
  logic [EXP_W-1:0]        res_exp;
  logic [3:0]              res_flags;

  assign s2_advance = !out_valid_q | out_ready;
  // rdy_en_q keeps in_ready low during reset and the first cycle after release.
  assign in_ready   = rdy_en_q & (!s1_valid_q | s2_advance);

  fp_lzc #(.W(SW)) u_lzc (
    .in_bits (in_mant[SW-1:0]),
    .count   (lz)
  );

  // Stage 1: normalise so the hidden bit sits at SW-1.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    rdy_en_d   = 1'b1;
    exp_in     = $signed({2'b00, in_exp});
    if (in_mant[SW]) begin
      shifted    = in_mant[SW:1];
      shifted[0] = in_mant[1] | in_mant[0];
      exp_n      = exp_in + EXP_ONE;
    end else begin
      shifted = in_mant[SW-1:0] << lz;
      exp_n   = exp_in - $signed({{(EXP_W+2-LZ_W){1'b0}}, lz});
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign = in_sign;
        s1_d.mant = shifted[SW-2:3];
        s1_d.exp  = exp_n;
        s1_d.grs  = shifted[2:0];
        s1_d.rm   = in_rm;
        s1_d.zero = (in_mant == '0);
      end
    end
  end

  // Stage 2: round, then apply zero / underflow / overflow.
  always_comb begin
    inexact = |s1_q.grs;
    case (s1_q.rm)
      RM_RNE:  round_up = s1_q.grs[2] & (s1_q.grs[1] | s1_q.grs[0] | s1_q.mant[0]);
      RM_RUP:  round_up = inexact & !s1_q.sign;
      RM_RDN:  round_up = inexact & s1_q.sign;
      default: round_up = 1'b0;
    endcase
    frac_sum = {1'b0, s1_q.mant} + {{MANT_W{1'b0}}, round_up};
    exp_r    = $signed(s1_q.exp);
    if (frac_sum[MANT_W]) exp_r = exp_r + EXP_ONE;
    ovf_to_inf = (s1_q.rm == RM_RNE) | ((s1_q.rm == RM_RUP) & !s1_q.sign) |
                 ((s1_q.rm == RM_RDN) & s1_q.sign);

    res_mant          = frac_sum[MANT_W-1:0];
    res_exp           = exp_r[EXP_W-1:0];
    res_flags         = '0;
    res_flags[FLG_NX] = inexact;
    if (s1_q.zero) begin
      res_mant            = '0;
      res_exp             = '0;
      res_flags           = '0;
      res_flags[FLG_ZERO] = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      res_mant            = '0;
      res_exp             = '0;
      res_flags[FLG_UF]   = 1'b1;
      res_flags[FLG_NX]   = 1'b1;
      res_flags[FLG_ZERO] = 1'b1;
    end else if (exp_r >= EXP_INF) begin
      res_flags[FLG_OF] = 1'b1;
      res_flags[FLG_NX] = 1'b1;
      if (ovf_to_inf) begin
        res_mant = '0;
        res_exp  = '1;
      end else begin
        res_mant = '1;
        res_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
      end
    end

    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_flags_d = out_flags_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d  = s1_q.sign;
        out_mant_d  = res_mant;
        out_exp_d   = res_exp;
        out_flags_d = res_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      rdy_en_q    <= rdy_en_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed bench for fp_norm_pipe at default widths; expected results are hand-computed.
module tb_fp_norm_pipe;
  import fp_norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [27:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic [1:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [22:0] out_mant;
  logic [7:0]  out_exp;
  logic [3:0]  out_flags;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  fp_norm_pipe #(.MANT_W(23), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mant(in_mant), .in_exp(in_exp), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mant(out_mant), .out_exp(out_exp), .out_flags(out_flags)
  );

  task automatic run_vec(input string name, input logic sg, input logic [27:0] m,
                         input logic [7:0] e, input logic [1:0] rm, input logic [7:0] xe,
                         input logic [22:0] xm, input logic [3:0] xf);
    @(negedge clk);
    in_valid = 1'b1; in_sign = sg; in_mant = m; in_exp = e; in_rm = rm; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready got %b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_mant = '0; in_exp = '0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s early out_valid got %b want 0", name, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_sign, out_exp, out_mant, out_flags} !== {1'b1, sg, xe, xm, xf}) begin
      n_err++;
      $display("FAIL %s got v=%b s=%b e=%h m=%h f=%h want v=1 s=%b e=%h m=%h f=%h", name,
               out_valid, out_sign, out_exp, out_mant, out_flags, sg, xe, xm, xf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, out_sign, out_exp, out_mant, out_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_values got v=%b rdy=%b s=%b e=%h m=%h f=%h want all 0",
               out_valid, in_ready, out_sign, out_exp, out_mant, out_flags);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_after got %b want 1", in_ready);
    end
  endtask

  task automatic test_normalise();
    run_vec("carry",      1'b0, 28'h8000000, 8'd127, RM_RNE, 8'd128, 23'h0, 4'h0);
    run_vec("carry_stk",  1'b0, 28'h8000001, 8'd127, RM_RNE, 8'd128, 23'h0, 4'h2);
    run_vec("left_shift", 1'b0, 28'h0100000, 8'd127, RM_RNE, 8'd121, 23'h0, 4'h0);
    run_vec("zero",       1'b0, 28'h0,       8'd100, RM_RNE, 8'd0,   23'h0, 4'h1);
    run_vec("zero_neg",   1'b1, 28'h0,       8'd100, RM_RTZ, 8'd0,   23'h0, 4'h1);
  endtask

  task automatic test_rounding();
    run_vec("rne_carry",  1'b0, 28'h7FFFFFF, 8'd127, RM_RNE, 8'd128, 23'h0,      4'h2);
    run_vec("rtz",        1'b0, 28'h7FFFFFF, 8'd127, RM_RTZ, 8'd127, 23'h7FFFFF, 4'h2);
    run_vec("rup_neg",    1'b1, 28'h7FFFFFF, 8'd127, RM_RUP, 8'd127, 23'h7FFFFF, 4'h2);
    run_vec("rdn_neg",    1'b1, 28'h7FFFFFF, 8'd127, RM_RDN, 8'd128, 23'h0,      4'h2);
    run_vec("tie_even",   1'b0, 28'h4000004, 8'd127, RM_RNE, 8'd127, 23'h0,      4'h2);
    run_vec("tie_odd",    1'b0, 28'h400000C, 8'd127, RM_RNE, 8'd127, 23'h2,      4'h2);
  endtask

  task automatic test_exceptions();
    run_vec("of_rne",     1'b0, 28'h8000000, 8'd254, RM_RNE, 8'hFF, 23'h0,      4'hA);
    run_vec("of_rtz",     1'b0, 28'h8000000, 8'd254, RM_RTZ, 8'hFE, 23'h7FFFFF, 4'hA);
    run_vec("of_rup_pos", 1'b0, 28'h8000000, 8'd254, RM_RUP, 8'hFF, 23'h0,      4'hA);
    run_vec("of_rup_neg", 1'b1, 28'h8000000, 8'd254, RM_RUP, 8'hFE, 23'h7FFFFF, 4'hA);
    run_vec("of_rdn_neg", 1'b1, 28'h8000000, 8'd254, RM_RDN, 8'hFF, 23'h0,      4'hA);
    run_vec("of_by_rnd",  1'b0, 28'h7FFFFFF, 8'd254, RM_RNE, 8'hFF, 23'h0,      4'hA);
    run_vec("uf",         1'b0, 28'h0100000, 8'd3,   RM_RNE, 8'h00, 23'h0,      4'h7);
    run_vec("uf_neg",     1'b1, 28'h4000000, 8'd0,   RM_RTZ, 8'h00, 23'h0,      4'h7);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic saw_drop = 1'b0;
    logic holding = 1'b0;
    logic [35:0] held = '0;
    logic [35:0] cur;
    logic [35:0] x;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 5) begin
        in_valid = 1'b1; in_sign = sent[0]; in_mant = 28'h4000000 | (28'(sent) << 3);
        in_exp = 8'(100 + sent); in_rm = RM_RNE;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      cur = {out_sign, out_exp, out_mant, out_flags};
      if (holding) begin
        n_cmp++;
        if (out_valid !== 1'b1 || cur !== held) begin
          n_err++; $display("FAIL stall_hold cycle %0d got v=%b %h want v=1 %h", c, out_valid, cur, held);
        end
      end
      holding = out_valid && !out_ready;
      held = cur;
      if (!in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back({sent[0], 8'(100 + sent), 23'(sent), 4'h0});
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra got %h want none", cur);
        end else begin
          x = exp_q.pop_front();
          if (cur !== x) begin
            n_err++; $display("FAIL b2b_data got %h want %h", cur, x);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got != 5 || exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_count got %0d left %0d want 5 left 0", got, exp_q.size());
    end
    n_cmp++;
    if (saw_drop !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready_drop got %b want 1", saw_drop);
    end
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sign = 1'b0; in_mant = 28'h8000000; in_exp = 8'd50; in_rm = RM_RNE;
    @(negedge clk);
    in_mant = 28'h4000008; in_exp = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL flight_valid got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL flight_reset got v=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL stale_beat cycle %0d got %b want 0", i, out_valid);
      end
    end
    run_vec("post_reset", 1'b1, 28'h0100000, 8'd127, RM_RNE, 8'd121, 23'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_normalise();
    test_rounding();
    test_exceptions();
    test_back_to_back();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
